// File: rtl/msg_block_buffer.sv
// msg_block_buffer: assembles the indexed host byte stream into 64-byte
// BLAKE2s message blocks. It zero-pads partial final blocks and keeps the
// 64-bit byte counter t. Each completed block is offered to the compression
// core over a valid/ack handshake.
//
// Optional build feature: define MSGBUF_IDX_CHECK_EN to enable the
// expected-index checker and its sticky err_o flag. Without the macro,
// err_o is tied to 0.
`timescale 1ns/1ps

module msg_block_buffer #(
    parameter int BB  = 64,
    parameter int T_W = 64
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   data_v_i,
    input  logic [7:0]             data_i,
    input  logic [$clog2(BB)-1:0]  data_idx_i,
    input  logic                   block_first_i,
    input  logic                   block_last_i,
    input  logic [T_W-1:0]         ll_i,
    output logic                   ready_o,
    output logic                   blk_v_o,
    input  logic                   blk_ack_i,
    output logic [8*BB-1:0]        m_o,
    output logic [T_W-1:0]         t_o,
    output logic                   first_o,
    output logic                   last_o,
    output logic                   err_o
);

    localparam int IDX_W = $clog2(BB);

    localparam logic ST_FILL = 1'b0;
    localparam logic ST_FULL = 1'b1;

    logic             state;
    logic [T_W-1:0]   t_q;
    logic [T_W-1:0]   t_inc;
    logic [8*BB-1:0]  m_q;
    logic [T_W-1:0]   t_out_q;
    logic             first_q;
    logic             last_q;
    logic             accept;
    logic             complete;
    logic             take;

    // Handshake qualifiers and the block-completion decision.
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        t_inc    = t_q + 1'b1;
        accept   = (state == ST_FILL) && data_v_i;
        take     = (state == ST_FULL) && blk_ack_i;
        complete = 1'b0;
        if (accept) begin
            // An ll_i of 0 never matches the counter, so such a message only closes on the last lane.
            if (data_idx_i == IDX_W'(BB - 1)) begin
                complete = 1'b1;
            end else if (block_last_i && (ll_i != '0) && (t_inc == ll_i)) begin
                complete = 1'b1;
            end
        end
    end

    // FILL/FULL control state: completion moves to FULL, ack returns to FILL.
    // NOTE: sequential state uses non-blocking assignments, so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state <= ST_FILL;
        end else if (complete) begin
            state <= ST_FULL;
        end else if (take) begin
            state <= ST_FILL;
        end
    end

    // Running byte counter t: counts accepted bytes and wraps at 2^T_W.
    // It clears only after the message's final block has been taken.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            t_q <= '0;
        end else if (accept) begin
            t_q <= t_inc;
        end else if (take && last_q) begin
            t_q <= '0;
        end
    end

    // Block lanes: write a byte into its lane, and clear all lanes after an ack so a partial block is zero-padded.
    // NOTE: the lane storage is deliberately reset. A discarded partial block must never leak into the next one, and m_o is observable from reset.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            m_q <= '0;
        end else if (accept) begin
            m_q[8*data_idx_i +: 8] <= data_i;
        end else if (take) begin
            m_q <= '0;
        end
    end

    // Block sideband: capture the count and the first/last flags at completion, then hold them while FULL.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            t_out_q <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (complete) begin
            t_out_q <= t_inc;
            first_q <= block_first_i;
            last_q  <= block_last_i;
        end
    end

`ifdef MSGBUF_IDX_CHECK_EN
    logic [IDX_W-1:0] e_q;
    logic             err_q;

    // Expected-index checker: e follows the accepted bytes, and any mismatch latches a sticky error.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            e_q   <= '0;
            err_q <= 1'b0;
        end else begin
            if (take) begin
                e_q <= '0;
            end else if (accept) begin
                e_q <= e_q + 1'b1;
            end
            if (accept && (data_idx_i != e_q)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign ready_o = (state == ST_FILL);
    assign blk_v_o = (state == ST_FULL);
    assign m_o     = m_q;
    assign t_o     = t_out_q;
    assign first_o = first_q;
    assign last_o  = last_q;

endmodule

// File: tb/tb_msg_block_buffer.sv
// tb_msg_block_buffer: scoreboard bench for msg_block_buffer. A byte-level
// model predicts each completed block and pushes it to a queue. The queue is
// popped and compared when the DUT presents the block.
`timescale 1ns/1ps

module tb_msg_block_buffer;

    logic         clk;
    logic         nreset;
    logic         data_v_i;
    logic [7:0]   data_i;
    logic [5:0]   data_idx_i;
    logic         block_first_i;
    logic         block_last_i;
    logic [63:0]  ll_i;
    logic         ready_o;
    logic         blk_v_o;
    logic         blk_ack_i;
    logic [511:0] m_o;
    logic [63:0]  t_o;
    logic         first_o;
    logic         last_o;
    logic         err_o;

    msg_block_buffer dut (
        .clk           (clk),
        .nreset        (nreset),
        .data_v_i      (data_v_i),
        .data_i        (data_i),
        .data_idx_i    (data_idx_i),
        .block_first_i (block_first_i),
        .block_last_i  (block_last_i),
        .ll_i          (ll_i),
        .ready_o       (ready_o),
        .blk_v_o       (blk_v_o),
        .blk_ack_i     (blk_ack_i),
        .m_o           (m_o),
        .t_o           (t_o),
        .first_o       (first_o),
        .last_o        (last_o),
        .err_o         (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] m;
        logic [63:0]  t;
        logic         first;
        logic         last;
    } blk_t;

    blk_t         exp_q[$];
    logic [511:0] mdl_m;
    logic [63:0]  mdl_t;
    bit           mdl_full;
    logic         mdl_last;
    int           n_total;
    int           n_pass;

    // Watchdog: a hung run reports and stops.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // One byte for one cycle. The model writes the lane, counts the byte,
    // and predicts completion from the spec rules.
    task automatic drive_byte(input logic [5:0] idx, input logic [7:0] d,
                              input logic f, input logic l);
        data_v_i = 1'b1; data_idx_i = idx; data_i = d;
        block_first_i = f; block_last_i = l;
        if (!mdl_full) begin
            mdl_m[8*idx +: 8] = d;
            mdl_t = mdl_t + 64'd1;
            if (idx == 6'd63 || (l && ll_i != 64'd0 && mdl_t == ll_i)) begin
                exp_q.push_back('{mdl_m, mdl_t, f, l});
                mdl_full = 1'b1;
                mdl_last = l;
            end
        end
        @(posedge clk); #1;
        data_v_i = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        nreset = 1'b0;
        repeat (cycles) begin @(posedge clk); #1; end
        nreset = 1'b1;
        mdl_m = '0; mdl_t = '0; mdl_full = 1'b0; mdl_last = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_ack(input string name);
        blk_ack_i = 1'b1;
        @(posedge clk); #1;
        blk_ack_i = 1'b0;
        if (mdl_full) begin
            mdl_full = 1'b0;
            mdl_m = '0;
            if (mdl_last) mdl_t = '0;
        end
        n_total++;
        if (blk_v_o !== 1'b0) $display("FAIL %s_ack_blk_v: got %b required 0", name, blk_v_o);
        else n_pass++;
        n_total++;
        if (ready_o !== 1'b1) $display("FAIL %s_ack_ready: got %b required 1", name, ready_o);
        else n_pass++;
    endtask

    // Call right after the final byte: blk_v_o must already be up (latency N+1).
    task automatic check_block(input string name);
        blk_t e;
        int   waited;
        n_total++;
        if (blk_v_o !== 1'b1) $display("FAIL %s_latency: blk_v_o got %b required 1", name, blk_v_o);
        else n_pass++;
        waited = 0;
        while (blk_v_o !== 1'b1 && waited < 4) begin
            @(posedge clk); #1;
            waited++;
        end
        n_total++;
        if (blk_v_o !== 1'b1) begin
            $display("FAIL %s_timeout: blk_v_o got %b required 1", name, blk_v_o);
            return;
        end
        n_pass++;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s_scoreboard: got block, required none pending", name);
            return;
        end
        n_pass++;
        e = exp_q.pop_front();
        n_total++;
        if (m_o !== e.m) $display("FAIL %s_m: got %h required %h", name, m_o, e.m);
        else n_pass++;
        n_total++;
        if (t_o !== e.t) $display("FAIL %s_t: got %0d required %0d", name, t_o, e.t);
        else n_pass++;
        n_total++;
        if (first_o !== e.first) $display("FAIL %s_first: got %b required %b", name, first_o, e.first);
        else n_pass++;
        n_total++;
        if (last_o !== e.last) $display("FAIL %s_last: got %b required %b", name, last_o, e.last);
        else n_pass++;
        n_total++;
        if (ready_o !== 1'b0) $display("FAIL %s_ready: got %b required 0", name, ready_o);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset(2);
        n_total++;
        if (ready_o !== 1'b1) $display("FAIL reset_ready: got %b required 1", ready_o); else n_pass++;
        n_total++;
        if (blk_v_o !== 1'b0) $display("FAIL reset_blk_v: got %b required 0", blk_v_o); else n_pass++;
        n_total++;
        if (m_o !== 512'd0) $display("FAIL reset_m: got %h required 0", m_o); else n_pass++;
        n_total++;
        if (t_o !== 64'd0) $display("FAIL reset_t: got %0d required 0", t_o); else n_pass++;
        n_total++;
        if (first_o !== 1'b0 || last_o !== 1'b0)
            $display("FAIL reset_flags: got %b%b required 00", first_o, last_o);
        else n_pass++;
        n_total++;
        if (err_o !== 1'b0) $display("FAIL reset_err: got %b required 0", err_o); else n_pass++;
    endtask

    task automatic test_full_block();
        ll_i = 64'd128;
        for (int k = 0; k < 64; k++) begin
            drive_byte(6'(k), 8'(k), 1'b1, 1'b0);
            if (k == 62) begin
                n_total++;
                if (blk_v_o !== 1'b0) $display("FAIL full_early: blk_v_o got %b required 0", blk_v_o);
                else n_pass++;
            end
        end
        check_block("full");
        n_total++;
        if (m_o[7:0] !== 8'h00 || m_o[511:504] !== 8'h3F)
            $display("FAIL full_lanes: got %h/%h required 00/3f", m_o[7:0], m_o[511:504]);
        else n_pass++;
        n_total++;
        if (t_o !== 64'd64 || first_o !== 1'b1)
            $display("FAIL full_t_first: got %0d/%b required 64/1", t_o, first_o);
        else n_pass++;
    endtask

    // Bytes offered while FULL are dropped, and the held block must not move.
    task automatic test_back_pressure();
        for (int i = 0; i < 10; i++) begin
            drive_byte(6'd0, 8'hFF, 1'b0, 1'b0);
            n_total++;
            if (m_o !== mdl_m || t_o !== 64'd64 || ready_o !== 1'b0 || blk_v_o !== 1'b1)
                $display("FAIL bp_hold_%0d: got m=%h t=%0d rdy=%b v=%b required m=%h t=64 rdy=0 v=1",
                         i, m_o, t_o, ready_o, blk_v_o, mdl_m);
            else n_pass++;
        end
        do_ack("bp");
    endtask

    task automatic test_partial_last();
        ll_i = 64'd67;
        drive_byte(6'd0, 8'hAA, 1'b0, 1'b1);
        drive_byte(6'd1, 8'hBB, 1'b0, 1'b1);
        drive_byte(6'd2, 8'hCC, 1'b0, 1'b1);
        check_block("partial");
        n_total++;
        if (t_o !== 64'd67 || last_o !== 1'b1)
            $display("FAIL partial_t_last: got %0d/%b required 67/1", t_o, last_o);
        else n_pass++;
        n_total++;
        if (m_o[23:0] !== 24'hCCBBAA || m_o[511:24] !== 488'd0)
            $display("FAIL partial_pad: got %h required %h", m_o, 512'hCCBBAA);
        else n_pass++;
        do_ack("partial");
    endtask

    // Two full blocks with ack in between. t restarts after the previous last block.
    task automatic test_back_to_back();
        ll_i = 64'd4096;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 64; k++)
                drive_byte(6'(k), 8'($urandom_range(255)), (b == 0), 1'b0);
            check_block($sformatf("b2b%0d", b));
            n_total++;
            if (t_o !== 64'(64 * (b + 1)))
                $display("FAIL b2b%0d_tcount: got %0d required %0d", b, t_o, 64 * (b + 1));
            else n_pass++;
            do_ack($sformatf("b2b%0d", b));
        end
    endtask

    // With ll_i=0 the block closes only at lane 63, and a non-last ack keeps t.
    task automatic test_ll_zero();
        ll_i = 64'd0;
        for (int k = 0; k < 64; k++) begin
            drive_byte(6'(k), 8'(k * 3), 1'b0, 1'b1);
            if (k == 3 || k == 62) begin
                n_total++;
                if (blk_v_o !== 1'b0) $display("FAIL llzero_early_%0d: blk_v_o got %b required 0", k, blk_v_o);
                else n_pass++;
            end
        end
        check_block("llzero");
        n_total++;
        if (t_o !== 64'd192) $display("FAIL llzero_t: got %0d required 192", t_o); else n_pass++;
        do_ack("llzero");
    endtask

    // A last block that is shorter than ll_i completes at lane 63 with last_o set.
    task automatic test_last_short();
        ll_i = 64'd1000;
        for (int k = 0; k < 64; k++)
            drive_byte(6'(k), 8'(255 - k), 1'b0, 1'b1);
        check_block("lastshort");
        n_total++;
        if (last_o !== 1'b1 || t_o !== 64'd64)
            $display("FAIL lastshort_flags: got last=%b t=%0d required 1/64", last_o, t_o);
        else n_pass++;
        do_ack("lastshort");
    endtask

    task automatic test_reset_mid();
        ll_i = 64'd128;
        for (int k = 0; k < 10; k++)
            drive_byte(6'(k), 8'h77, 1'b1, 1'b0);
        do_reset(1);
        for (int k = 0; k < 64; k++)
            drive_byte(6'(k), 8'(k) ^ 8'h5A, 1'b1, 1'b0);
        check_block("rstmid");
        n_total++;
        if (t_o !== 64'd64) $display("FAIL rstmid_t: got %0d required 64", t_o); else n_pass++;
        do_ack("rstmid");
    endtask

    task automatic test_idx_err();
        logic exp_err;
`ifdef MSGBUF_IDX_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_reset(1);
        ll_i = 64'd128;
        drive_byte(6'd0, 8'h10, 1'b1, 1'b0);
        drive_byte(6'd1, 8'h11, 1'b1, 1'b0);
        n_total++;
        if (err_o !== 1'b0) $display("FAIL idx_before: err_o got %b required 0", err_o); else n_pass++;
        drive_byte(6'd3, 8'h13, 1'b1, 1'b0);
        n_total++;
        if (err_o !== exp_err) $display("FAIL idx_set: err_o got %b required %b", err_o, exp_err);
        else n_pass++;
        repeat (3) begin @(posedge clk); #1; end
        n_total++;
        if (err_o !== exp_err) $display("FAIL idx_sticky: err_o got %b required %b", err_o, exp_err);
        else n_pass++;
        n_total++;
        if (m_o[31:24] !== 8'h13 || m_o[23:16] !== 8'h00)
            $display("FAIL idx_lane: got %h/%h required 13/00", m_o[31:24], m_o[23:16]);
        else n_pass++;
    endtask

    initial begin
        n_total = 0; n_pass = 0;
        nreset = 1'b0; data_v_i = 1'b0; data_i = '0; data_idx_i = '0;
        block_first_i = 1'b0; block_last_i = 1'b0; ll_i = '0; blk_ack_i = 1'b0;
        mdl_m = '0; mdl_t = '0; mdl_full = 1'b0; mdl_last = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_full_block();
        test_back_pressure();
        test_partial_last();
        test_back_to_back();
        test_ll_zero();
        test_last_short();
        test_reset_mid();
        test_idx_err();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
